rv32_decode_exec: RTL and testbench



---
 rtl/rv32_decode_exec_if.sv | 30 +++
 rtl/rv32_decode_exec.sv | 191 +++++++++++++++++++
 tb/tb_rv32_decode_exec.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_decode_exec_if.sv
// Decode/execute stage bus: instruction and operands in, registered results out.
// rs1/rs2 are driven combinationally by the stage for same-cycle register-file reads.
interface rv32_decode_exec_if #(
   parameter int WORD_LENGTH = 32
);
   logic                   in_valid;
   logic [31:0]            inst;
   logic [WORD_LENGTH-1:0] pc;
   logic [WORD_LENGTH-1:0] rs1_data;
   logic [WORD_LENGTH-1:0] rs2_data;
   logic [4:0]             rs1;
   logic [4:0]             rs2;
   logic                   out_valid;
   logic [WORD_LENGTH-1:0] alu_result;
   logic [WORD_LENGTH-1:0] wb_data;
   logic [4:0]             rd_q;
   logic                   rd_we;
   logic [WORD_LENGTH-1:0] next_pc;
   logic                   taken;

   modport master (
      output in_valid, inst, pc, rs1_data, rs2_data,
      input  rs1, rs2, out_valid, alu_result, wb_data, rd_q, rd_we, next_pc, taken
   );

   modport slave (
      input  in_valid, inst, pc, rs1_data, rs2_data,
      output rs1, rs2, out_valid, alu_result, wb_data, rd_q, rd_we, next_pc, taken
   );
endinterface

// File: rtl/rv32_decode_exec.sv
// Registered RV32I decode-and-execute stage: decode, operand select, ALU, branch
// compare, and one-cycle capture of result, write-back, next PC and control flags.

// Generic key/value mux: value of the first matching key, zero when nothing matches.
module rv32_kv_mux #(
   parameter int unsigned N  = 2,
   parameter int unsigned KW = 7,
   parameter int unsigned DW = 32
) (
   input  logic [KW-1:0]         sel,
   input  logic [N-1:0][KW-1:0]  keys,
   input  logic [N-1:0][DW-1:0]  values,
   output logic [DW-1:0]         out
);
   logic hit;

   always_comb begin
      out = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!hit && sel == keys[i]) begin
            out = values[i];
            hit = 1'b1;
         end
      end
   end
endmodule

module rv32_decode_exec #(
   parameter int WORD_LENGTH = 32
) (
   input logic               clk,
   input logic               rst,
   rv32_decode_exec_if.slave bus
);
   localparam int W = WORD_LENGTH;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   logic [31:0]  inst;
   logic [6:0]   opcode;
   logic [4:0]   rd;
   logic [2:0]   funct3;
   logic         alt;
   logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [W-1:0] pc_plus4;

   assign inst     = bus.inst;
   assign opcode   = inst[6:0];
   assign rd       = inst[11:7];
   assign funct3   = inst[14:12];
   assign alt      = inst[30];
   assign bus.rs1  = inst[19:15];
   assign bus.rs2  = inst[24:20];
   assign pc_plus4 = bus.pc + W'(4);

   assign imm_i = W'($signed(inst[31:20]));
   assign imm_s = W'($signed({inst[31:25], inst[11:7]}));
   assign imm_b = W'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign imm_u = W'($signed({inst[31:12], 12'b0}));
   assign imm_j = W'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

   logic is_op, is_op_imm, is_jal, is_jalr, is_branch;
   logic writes_rd;

   assign is_op     = (opcode == OPC_OP);
   assign is_op_imm = (opcode == OPC_OP_IMM);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign writes_rd = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || is_jal || is_jalr
                      || is_op || is_op_imm;

   // Operand selection tables
   logic [7:0][6:0]   src1_keys, src2_keys;
   logic [7:0][W-1:0] src1_vals, src2_vals;
   logic [5:0][6:0]   wb_keys;
   logic [5:0][W-1:0] wb_vals;
   logic [W-1:0]      src1, src2, alu, wb;

   always_comb begin
      src1_keys[0] = OPC_AUIPC;  src1_vals[0] = bus.pc;
      src1_keys[1] = OPC_JAL;    src1_vals[1] = bus.pc;
      src1_keys[2] = OPC_BRANCH; src1_vals[2] = bus.pc;
      src1_keys[3] = OPC_JALR;   src1_vals[3] = bus.rs1_data;
      src1_keys[4] = OPC_OP_IMM; src1_vals[4] = bus.rs1_data;
      src1_keys[5] = OPC_OP;     src1_vals[5] = bus.rs1_data;
      src1_keys[6] = OPC_LOAD;   src1_vals[6] = bus.rs1_data;
      src1_keys[7] = OPC_STORE;  src1_vals[7] = bus.rs1_data;

      src2_keys[0] = OPC_AUIPC;  src2_vals[0] = imm_u;
      src2_keys[1] = OPC_JAL;    src2_vals[1] = imm_j;
      src2_keys[2] = OPC_JALR;   src2_vals[2] = imm_i;
      src2_keys[3] = OPC_OP_IMM; src2_vals[3] = imm_i;
      src2_keys[4] = OPC_LOAD;   src2_vals[4] = imm_i;
      src2_keys[5] = OPC_BRANCH; src2_vals[5] = imm_b;
      src2_keys[6] = OPC_STORE;  src2_vals[6] = imm_s;
      src2_keys[7] = OPC_OP;     src2_vals[7] = bus.rs2_data;

      wb_keys[0] = OPC_LUI;    wb_vals[0] = imm_u;
      wb_keys[1] = OPC_JAL;    wb_vals[1] = pc_plus4;
      wb_keys[2] = OPC_JALR;   wb_vals[2] = pc_plus4;
      wb_keys[3] = OPC_AUIPC;  wb_vals[3] = alu;
      wb_keys[4] = OPC_OP;     wb_vals[4] = alu;
      wb_keys[5] = OPC_OP_IMM; wb_vals[5] = alu;
   end

   rv32_kv_mux #(.N(8), .KW(7), .DW(W)) u_src1_mux (
      .sel(opcode), .keys(src1_keys), .values(src1_vals), .out(src1)
   );

   rv32_kv_mux #(.N(8), .KW(7), .DW(W)) u_src2_mux (
      .sel(opcode), .keys(src2_keys), .values(src2_vals), .out(src2)
   );

   rv32_kv_mux #(.N(6), .KW(7), .DW(W)) u_wb_mux (
      .sel(opcode), .keys(wb_keys), .values(wb_vals), .out(wb)
   );

   // Non-arithmetic opcodes reuse the ALU as a plain adder.
   logic [2:0] f3_eff;
   logic [4:0] shamt;

   always_comb begin
      f3_eff = (is_op || is_op_imm) ? funct3 : 3'b000;
      shamt  = src2[4:0];
      alu    = '0;
      case (f3_eff)
         3'b000: begin
            if (is_op && alt) alu = src1 - src2;
            else              alu = src1 + src2;
         end
         3'b001: alu = src1 << shamt;
         3'b010: alu = {{(W-1){1'b0}}, ($signed(src1) < $signed(src2))};
         3'b011: alu = {{(W-1){1'b0}}, (src1 < src2)};
         3'b100: alu = src1 ^ src2;
         3'b101: begin
            if (alt) alu = $signed(src1) >>> shamt;
            else     alu = src1 >> shamt;
         end
         3'b110: alu = src1 | src2;
         default: alu = src1 & src2;
      endcase
   end

   logic br_cond, take;

   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         3'b000: br_cond = (bus.rs1_data == bus.rs2_data);
         3'b001: br_cond = (bus.rs1_data != bus.rs2_data);
         3'b100: br_cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
         3'b101: br_cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
         3'b110: br_cond = (bus.rs1_data <  bus.rs2_data);
         3'b111: br_cond = (bus.rs1_data >= bus.rs2_data);
         default: br_cond = 1'b0;
      endcase
      take = is_jal || is_jalr || (is_branch && br_cond);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.alu_result <= '0;
         bus.wb_data    <= '0;
         bus.rd_q       <= '0;
         bus.rd_we      <= 1'b0;
         bus.next_pc    <= '0;
         bus.taken      <= 1'b0;
      end else begin
         bus.out_valid  <= bus.in_valid;
         bus.alu_result <= alu;
         bus.wb_data    <= wb;
         bus.rd_q       <= rd;
         bus.rd_we      <= bus.in_valid && writes_rd && (rd != 5'd0);
         bus.next_pc    <= take ? {alu[W-1:1], 1'b0} : pc_plus4;
         bus.taken      <= bus.in_valid && take;
      end
   end
endmodule

// File: tb/tb_rv32_decode_exec.sv
// Self-checking bench for rv32_decode_exec: directed cases plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_rv32_decode_exec;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   rv32_decode_exec_if #(.WORD_LENGTH(32)) bus ();

   rv32_decode_exec #(.WORD_LENGTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic        ov;
      logic [31:0] alu;
      logic [31:0] wb;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] npc;
      logic        tk;
   } res_t;

   function automatic string fmt(input res_t r);
      return $sformatf("ov=%0b alu=%h wb=%h rd=%0d we=%0b npc=%h tk=%0b",
                       r.ov, r.alu, r.wb, r.rd, r.we, r.npc, r.tk);
   endfunction

   function automatic res_t sample();
      res_t r;
      r.ov  = bus.out_valid;
      r.alu = bus.alu_result;
      r.wb  = bus.wb_data;
      r.rd  = bus.rd_q;
      r.we  = bus.rd_we;
      r.npc = bus.next_pc;
      r.tk  = bus.taken;
      return r;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic reg_op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      case (f3)
         3'd0: return (reg_op && alt) ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (alt) begin
               sa = sa >>> b[4:0];
               return sa;
            end
            return a >> b[4:0];
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic branch_ref(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Instruction-level model: what each opcode architecturally produces.
   function automatic res_t model(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic valid);
      res_t r;
      logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
      logic jump, writes;
      i_imm = {{20{inst[31]}}, inst[31:20]};
      s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      u_imm = {inst[31:12], 12'b0};
      j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      r = '0;
      jump = 1'b0;
      writes = 1'b0;
      case (inst[6:0])
         7'b0110111: begin r.wb = u_imm; writes = 1'b1; end
         7'b0010111: begin r.alu = pc + u_imm; r.wb = r.alu; writes = 1'b1; end
         7'b1101111: begin r.alu = pc + j_imm; r.wb = pc + 4; writes = 1'b1; jump = 1'b1; end
         7'b1100111: begin r.alu = a + i_imm; r.wb = pc + 4; writes = 1'b1; jump = 1'b1; end
         7'b1100011: begin r.alu = pc + b_imm; jump = branch_ref(inst[14:12], a, b); end
         7'b0000011: r.alu = a + i_imm;
         7'b0100011: r.alu = a + s_imm;
         7'b0010011: begin
            r.alu = alu_ref(inst[14:12], inst[30], 1'b0, a, i_imm);
            r.wb = r.alu; writes = 1'b1;
         end
         7'b0110011: begin
            r.alu = alu_ref(inst[14:12], inst[30], 1'b1, a, b);
            r.wb = r.alu; writes = 1'b1;
         end
         default: ;
      endcase
      r.npc = jump ? {r.alu[31:1], 1'b0} : pc + 4;
      r.tk  = jump && valid;
      r.we  = writes && (inst[11:7] != 5'd0) && valid;
      r.rd  = inst[11:7];
      r.ov  = valid;
      return r;
   endfunction

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic valid);
      bus.inst = inst;
      bus.pc = pc;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.in_valid = valid;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      res_t got, exp;
      rst = 1'b1;
      drive(32'h00500093, 32'h0000_1000, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         got = sample();
         vectors++;
         if (got !== res_t'('0)) begin
            miscompares++;
            $display("FAIL reset%0d: got %s, expected all zero", i, fmt(got));
         end
      end
      rst = 1'b0;
      tick();
      got = sample();
      exp = '{ov: 1'b1, alu: 32'd5, wb: 32'd5, rd: 5'd1, we: 1'b1, npc: 32'h0000_1004, tk: 1'b0};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL addi_after_reset: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   typedef struct {
      logic [31:0] inst, pc, a, b;
      int          sel;   // 0 alu, 1 wb, 2 next_pc, 3 rd_we, 4 taken
      logic [31:0] val;
   } dvec_t;

   task automatic test_directed();
      dvec_t tab[13];
      res_t got, exp;
      logic [31:0] key;
      tab = '{
         '{32'h402081B3, 32'h0000_1000, 32'd3,          32'd5,  0, 32'hFFFF_FFFE}, // sub
         '{32'h40208193, 32'h0000_1000, 32'd3,          32'd5,  0, 32'h0000_0405}, // addi, never sub
         '{32'h40435293, 32'h0000_1000, 32'h8000_0000,  32'd0,  0, 32'hF800_0000}, // srai
         '{32'h00435293, 32'h0000_1000, 32'h8000_0000,  32'd0,  0, 32'h0800_0000}, // srli
         '{32'h003120B3, 32'h0000_1000, 32'hFFFF_FFFF,  32'd1,  0, 32'd1},         // slt
         '{32'h003130B3, 32'h0000_1000, 32'hFFFF_FFFF,  32'd1,  0, 32'd0},         // sltu
         '{32'h00208463, 32'h8000_0000, 32'd7,          32'd7,  2, 32'h8000_0008}, // beq taken
         '{32'h00208463, 32'h8000_0000, 32'd7,          32'd7,  4, 32'd1},
         '{32'h00208463, 32'h8000_0000, 32'd7,          32'd8,  2, 32'h8000_0004}, // beq not taken
         '{32'h004100E7, 32'h8000_0010, 32'h8000_0101,  32'd0,  2, 32'h8000_0104}, // jalr
         '{32'h004100E7, 32'h8000_0010, 32'h8000_0101,  32'd0,  1, 32'h8000_0014},
         '{32'h123453B7, 32'h0000_1000, 32'd0,          32'd0,  1, 32'h1234_5000}, // lui
         '{32'hFE20AE23, 32'h0000_1000, 32'h0000_0100,  32'd9,  0, 32'h0000_00FC}  // sw -4
      };
      foreach (tab[k]) begin
         drive(tab[k].inst, tab[k].pc, tab[k].a, tab[k].b, 1'b1);
         tick();
         got = sample();
         exp = model(tab[k].inst, tab[k].pc, tab[k].a, tab[k].b, 1'b1);
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL dir%0d_model: got %s, expected %s", k, fmt(got), fmt(exp));
         end
         case (tab[k].sel)
            0: key = got.alu;
            1: key = got.wb;
            2: key = got.npc;
            3: key = {31'd0, got.we};
            default: key = {31'd0, got.tk};
         endcase
         vectors++;
         if (key !== tab[k].val) begin
            miscompares++;
            $display("FAIL dir%0d_field%0d: got %h, expected %h", k, tab[k].sel, key, tab[k].val);
         end
      end
   endtask

   task automatic test_no_write();
      res_t got;
      // addi x0,x0,5, beq not taken, sw: none may write a register
      logic [31:0] insts[3];
      insts = '{32'h00500013, 32'h00208463, 32'hFE20AE23};
      foreach (insts[k]) begin
         drive(insts[k], 32'h8000_0000, 32'd1, 32'd2, 1'b1);
         tick();
         got = sample();
         vectors++;
         if (got.we !== 1'b0) begin
            miscompares++;
            $display("FAIL no_write%0d: got rd_we=%0b, expected 0", k, got.we);
         end
      end
   endtask

   task automatic test_invalid();
      res_t got, exp;
      drive(32'h008000EF, 32'h0000_2000, 32'd0, 32'd0, 1'b0);   // jal x1,8 not valid
      tick();
      got = sample();
      vectors++;
      if ({got.ov, got.we, got.tk} !== 3'b000) begin
         miscompares++;
         $display("FAIL invalid_jal: got ov=%0b we=%0b tk=%0b, expected 0 0 0", got.ov, got.we, got.tk);
      end
      drive(32'h008000EF, 32'h0000_2000, 32'd0, 32'd0, 1'b1);
      tick();
      got = sample();
      exp = '{ov: 1'b1, alu: 32'h0000_2008, wb: 32'h0000_2004, rd: 5'd1, we: 1'b1,
              npc: 32'h0000_2008, tk: 1'b1};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL valid_jal: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_random_back_to_back();
      logic [6:0] ops[10];
      logic [31:0] inst, pc, a, b;
      logic valid, do_rst;
      res_t got, exp;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0000000};
      for (int n = 0; n < 3000; n++) begin
         inst = $urandom;
         inst[6:0] = ops[$urandom_range(0, 9)];
         if (inst[6:0] == 7'b0000000) inst[6:0] = 7'($urandom);
         pc = $urandom & 32'hFFFF_FFFC;
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         valid = ($urandom_range(0, 7) != 0);
         do_rst = ($urandom_range(0, 49) == 0);
         rst = do_rst;
         drive(inst, pc, a, b, valid);
         #1;
         vectors++;
         if ({bus.rs1, bus.rs2} !== {inst[19:15], inst[24:20]}) begin
            miscompares++;
            $display("FAIL rnd%0d_rs: got rs1=%0d rs2=%0d, expected %0d %0d",
                     n, bus.rs1, bus.rs2, inst[19:15], inst[24:20]);
         end
         tick();
         got = sample();
         exp = do_rst ? res_t'('0) : model(inst, pc, a, b, valid);
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL rnd%0d inst=%h: got %s, expected %s", n, inst, fmt(got), fmt(exp));
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      test_reset();
      test_directed();
      test_no_write();
      test_invalid();
      test_random_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
